// File: rtl/io_port_controller.sv
// External-side I/O partner for the processor: an input FIFO feeds in_port and
// raises a fixed-width interrupt pulse while data waits; an output FIFO captures out_port writes.

// Generic single-clock FIFO. The head is combinational and reads as 0 when empty.
module io_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wr_data,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign head  = empty ? '0 : mem[rd_ptr];
endmodule

module io_port_controller #(
  parameter int W        = 16,
  parameter int DEPTH    = 4,
  parameter int IRQ_HOLD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [W-1:0]             ext_in_data,
  input  logic                     ext_in_valid,
  output logic                     ext_in_ready,
  output logic [W-1:0]             in_port,
  input  logic                     in_rd,
  input  logic                     irq_en,
  output logic                     interrupt,
  output logic [$clog2(DEPTH):0]   in_count,
  input  logic [W-1:0]             out_port,
  input  logic                     out_wr,
  output logic                     out_full,
  output logic                     out_ovf,
  output logic [W-1:0]             ext_out_data,
  output logic                     ext_out_valid,
  input  logic                     ext_out_ready
);
  localparam int CNTW = (IRQ_HOLD > 1) ? $clog2(IRQ_HOLD) : 1;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_ASSERT,
    IRQ_SERVICE
  } irq_state_t;

  logic in_empty, in_full, in_push, in_pop;
  logic out_empty, out_push, out_pop;
  logic [$clog2(DEPTH):0] out_count;

  assign ext_in_ready = !in_full;
  assign in_push      = ext_in_valid & ext_in_ready;
  assign in_pop       = in_rd & !in_empty;

  io_fifo #(.W(W), .DEPTH(DEPTH)) u_in_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_push),
    .pop     (in_pop),
    .wr_data (ext_in_data),
    .head    (in_port),
    .count   (in_count),
    .empty   (in_empty),
    .full    (in_full)
  );

  // A full output FIFO still takes a write when the head drains in the same cycle.
  assign ext_out_valid = !out_empty;
  assign out_pop       = ext_out_valid & ext_out_ready;
  assign out_push      = out_wr & (!out_full | out_pop);

  io_fifo #(.W(W), .DEPTH(DEPTH)) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (out_push),
    .pop     (out_pop),
    .wr_data (out_port),
    .head    (ext_out_data),
    .count   (out_count),
    .empty   (out_empty),
    .full    (out_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out_ovf <= 1'b0;
    else if (out_wr & out_full & !out_pop) out_ovf <= 1'b1;
  end

  irq_state_t      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IRQ_IDLE;
      cnt_q     <= '0;
      interrupt <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      interrupt <= (state_d == IRQ_ASSERT);
    end
  end

  // irq_en only gates entry to ASSERT; a started pulse always runs IRQ_HOLD cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IRQ_IDLE: begin
        if (irq_en && !in_empty) begin
          state_d = IRQ_ASSERT;
          cnt_d   = CNTW'(IRQ_HOLD - 1);
        end
      end
      IRQ_ASSERT: begin
        if (cnt_q == '0) state_d = IRQ_SERVICE;
        else             cnt_d   = cnt_q - CNTW'(1);
      end
      IRQ_SERVICE: begin
        if (in_pop || in_empty) state_d = IRQ_IDLE;
      end
      default: state_d = IRQ_IDLE;
    endcase
  end
endmodule

// File: tb/tb_io_port_controller.sv
// Bench for io_port_controller: directed scenarios plus random traffic checked
// against queue-based FIFO models.
module tb_io_port_controller;
  localparam int W        = 16;
  localparam int DEPTH    = 4;
  localparam int IRQ_HOLD = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] ext_in_data = '0;
  logic         ext_in_valid = 1'b0;
  logic         ext_in_ready;
  logic [W-1:0] in_port;
  logic         in_rd = 1'b0;
  logic         irq_en = 1'b0;
  logic         interrupt;
  logic [$clog2(DEPTH):0] in_count;
  logic [W-1:0] out_port = '0;
  logic         out_wr = 1'b0;
  logic         out_full;
  logic         out_ovf;
  logic [W-1:0] ext_out_data;
  logic         ext_out_valid;
  logic         ext_out_ready = 1'b0;

  always #5 clk = ~clk;

  io_port_controller #(.W(W), .DEPTH(DEPTH), .IRQ_HOLD(IRQ_HOLD)) dut (
    .clk           (clk),
    .rst           (rst),
    .ext_in_data   (ext_in_data),
    .ext_in_valid  (ext_in_valid),
    .ext_in_ready  (ext_in_ready),
    .in_port       (in_port),
    .in_rd         (in_rd),
    .irq_en        (irq_en),
    .interrupt     (interrupt),
    .in_count      (in_count),
    .out_port      (out_port),
    .out_wr        (out_wr),
    .out_full      (out_full),
    .out_ovf       (out_ovf),
    .ext_out_data  (ext_out_data),
    .ext_out_valid (ext_out_valid),
    .ext_out_ready (ext_out_ready)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] inq[$];
  logic [W-1:0] outq[$];
  bit m_ovf = 1'b0;

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  task automatic check_model(string tag);
    logic [W-1:0] ein, eout;
    ein  = '0;
    eout = '0;
    if (inq.size() != 0)  ein  = inq[0];
    if (outq.size() != 0) eout = outq[0];
    chk({tag, ":in_port"},       in_port,       ein);
    chk({tag, ":in_count"},      in_count,      inq.size());
    chk({tag, ":ext_in_ready"},  ext_in_ready,  inq.size() < DEPTH);
    chk({tag, ":out_full"},      out_full,      outq.size() == DEPTH);
    chk({tag, ":out_ovf"},       out_ovf,       m_ovf);
    chk({tag, ":ext_out_valid"}, ext_out_valid, outq.size() != 0);
    chk({tag, ":ext_out_data"},  ext_out_data,  eout);
  endtask

  // One clock: the model decides from the pre-edge state, then applies after the edge.
  task automatic tick();
    bit i_push, i_pop, o_pop, o_acc;
    logic [W-1:0] idat, odat;
    i_push = ext_in_valid && (inq.size() < DEPTH);
    i_pop  = in_rd && (inq.size() > 0);
    o_pop  = ext_out_ready && (outq.size() > 0);
    o_acc  = out_wr && ((outq.size() < DEPTH) || o_pop);
    idat   = ext_in_data;
    odat   = out_port;
    @(posedge clk);
    if (i_pop)  void'(inq.pop_front());
    if (i_push) inq.push_back(idat);
    if (o_pop)  void'(outq.pop_front());
    if (o_acc)  outq.push_back(odat);
    if (out_wr && !o_acc) m_ovf = 1'b1;
    #1;
  endtask

  task automatic apply_reset(string tag);
    rst = 1'b0;
    #1;
    inq.delete();
    outq.delete();
    m_ovf = 1'b0;
    check_model(tag);
    chk({tag, ":interrupt"}, interrupt, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [W-1:0] exp_in[6];
    logic [W-1:0] exp_out[4];
    int pulses, width, gap, bad_w, bad_gap, highs, k;
    bit prev, svc;

    #2;
    apply_reset("reset");

    // Single input word and its interrupt pulse.
    ext_in_valid = 1'b1; ext_in_data = 16'h00A5; irq_en = 1'b1;
    tick();
    ext_in_valid = 1'b0;
    check_model("s1_push");
    chk("s1_in_port", in_port, 16'h00A5);
    chk("s1_irq_pre", interrupt, 0);
    tick(); chk("s1_irq_hi1", interrupt, 1);
    tick(); chk("s1_irq_hi2", interrupt, 1);
    tick(); chk("s1_irq_lo", interrupt, 0);
    tick(); chk("s1_irq_svc", interrupt, 0);
    in_rd = 1'b1; tick(); in_rd = 1'b0;
    check_model("s1_pop");
    chk("s1_in_port_empty", in_port, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("s1_idle_irq", interrupt, 0);
    end
    irq_en = 1'b0;

    // Input full and pointer wrap.
    exp_in = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6};
    for (int i = 1; i <= 4; i++) begin
      ext_in_valid = 1'b1; ext_in_data = W'(i); tick();
    end
    ext_in_data = 16'hFFFF; tick();
    ext_in_valid = 1'b0;
    check_model("s2_full");
    chk("s2_ready", ext_in_ready, 0);
    chk("s2_count", in_count, 4);
    in_rd = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("s2_pop_head", in_port, exp_in[i]); tick();
    end
    in_rd = 1'b0;
    for (int i = 5; i <= 6; i++) begin
      ext_in_valid = 1'b1; ext_in_data = W'(i); tick();
    end
    ext_in_valid = 1'b0;
    check_model("s2_wrap");
    in_rd = 1'b1;
    for (int i = 2; i < 6; i++) begin
      chk("s2_drain_head", in_port, exp_in[i]); tick();
    end
    tick();
    in_rd = 1'b0;
    chk("s2_empty_rd", in_count, 0);
    check_model("s2_end");

    // Output backpressure and overflow.
    exp_out = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    ext_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      out_wr = 1'b1; out_port = exp_out[i]; tick();
    end
    chk("s3_full", out_full, 1);
    out_port = 16'h5555; tick();
    out_wr = 1'b0;
    chk("s3_ovf", out_ovf, 1);
    check_model("s3_drop");
    ext_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("s3_drain", ext_out_data, exp_out[i]); tick();
    end
    ext_out_ready = 1'b0;
    chk("s3_ovf_sticky", out_ovf, 1);
    chk("s3_empty", ext_out_valid, 0);

    apply_reset("reset2");

    // Write and drain on a full output FIFO in the same cycle.
    for (int i = 0; i < 4; i++) begin
      out_wr = 1'b1; out_port = exp_out[i]; tick();
    end
    out_port = 16'h7777; ext_out_ready = 1'b1;
    chk("s4_head", ext_out_data, 16'h1111);
    tick();
    out_wr = 1'b0;
    chk("s4_still_full", out_full, 1);
    chk("s4_no_ovf", out_ovf, 0);
    exp_out = '{16'h2222, 16'h3333, 16'h4444, 16'h7777};
    for (int i = 0; i < 4; i++) begin
      chk("s4_drain", ext_out_data, exp_out[i]); tick();
    end
    ext_out_ready = 1'b0;
    check_model("s4_end");

    // Three pending words, each interrupt serviced by one read.
    irq_en = 1'b1;
    pulses = 0; width = 0; gap = 0; bad_w = 0; bad_gap = 0; prev = 1'b0; svc = 1'b0;
    for (int c = 0; c < 80; c++) begin
      ext_in_valid = (c < 3);
      ext_in_data  = W'(16'hB000 + c);
      in_rd = svc; svc = 1'b0;
      tick();
      if (interrupt) begin
        if (!prev) begin
          pulses++;
          if (pulses > 1 && gap < 1) bad_gap++;
        end
        width++;
      end else if (prev) begin
        if (width != IRQ_HOLD) bad_w++;
        width = 0; gap = 1; svc = 1'b1;
      end else begin
        gap++;
      end
      prev = interrupt;
    end
    ext_in_valid = 1'b0; in_rd = 1'b0;
    chk("s5_pulses", pulses, 3);
    chk("s5_width_bad", bad_w, 0);
    chk("s5_gap_bad", bad_gap, 0);
    check_model("s5_end");

    // Same traffic with interrupts disabled: no pulses at all.
    irq_en = 1'b0; highs = 0;
    for (int c = 0; c < 20; c++) begin
      ext_in_valid = (c < 2); ext_in_data = W'(16'hD000 + c);
      tick();
      if (interrupt) highs++;
    end
    ext_in_valid = 1'b0;
    chk("s5_noirq", highs, 0);
    in_rd = 1'b1; tick(); tick(); in_rd = 1'b0;
    check_model("s5_noirq_end");

    // Asynchronous reset in the middle of a pulse.
    irq_en = 1'b1;
    ext_in_valid = 1'b1; ext_in_data = 16'hC0DE;
    out_wr = 1'b1; out_port = 16'hBEEF; ext_out_ready = 1'b0;
    tick();
    ext_in_valid = 1'b0; out_wr = 1'b0;
    k = 0;
    while (!interrupt && k < 10) begin
      tick(); k++;
    end
    chk("s6_irq_seen", interrupt, 1);
    #2;
    rst = 1'b0;
    #1;
    inq.delete(); outq.delete(); m_ovf = 1'b0;
    chk("s6_irq_async", interrupt, 0);
    check_model("s6_async");
    @(posedge clk); #1;
    rst = 1'b1;
    highs = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (interrupt) highs++;
    end
    chk("s6_quiet", highs, 0);
    ext_in_valid = 1'b1; ext_in_data = 16'h0042; tick();
    ext_in_valid = 1'b0;
    tick();
    chk("s6_new_irq", interrupt, 1);
    irq_en = 1'b0;
    apply_reset("reset3");

    // Random traffic against the queue models.
    for (int c = 0; c < 400; c++) begin
      ext_in_valid  = $urandom_range(0, 1) == 1;
      ext_in_data   = W'($urandom);
      in_rd         = $urandom_range(0, 2) == 0;
      out_wr        = $urandom_range(0, 2) != 0;
      out_port      = W'($urandom);
      ext_out_ready = $urandom_range(0, 2) == 0;
      tick();
      check_model("rand");
      chk("rand:interrupt", interrupt, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
